dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive DMA-wait cycles before the CPU is forcibly stalled (legal range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cpu_rd, cpu_wr  input  1 each  MEM-stage read/write strobes.
REQ-005 SHALL have ports cpu_addr  input  7  word address; cpu_wdata  input  32  store data.
REQ-006 SHALL have ports cpu_rdata  output  32  load data; cpu_stall  output  1  freeze-pipeline request.
REQ-007 SHALL have ports dma_req, dma_we  input  1 each  DMA request and write-enable (0 = read).
REQ-008 SHALL have ports dma_addr  input  7; dma_wdata  input  32.
REQ-009 SHALL have ports dma_gnt  output  1; dma_rvalid  output  1; dma_rdata  output  32.
REQ-010 SHALL have ports dm_addr  output  7; dm_rd, dm_wr  output  1 each; dm_wdata  output  32; dm_rdata  input  32 (combinational read data from the data memory).

Function
REQ-011 SHALL perform at most one memory access per cycle, selected by dma_sel.
REQ-012 SHALL define cpu_act = cpu_rd | cpu_wr; dma_sel = dma_req & (~cpu_act | wait_cnt == STARVE_LIMIT) & ~reset.
REQ-013 SHALL drive dm_* from DMA fields when dma_sel, else from CPU fields; dm_wr = dma_we when DMA selected, dm_rd = ~dma_we when DMA selected.
REQ-014 SHALL treat cpu_rd & cpu_wr both high as a write: dm_wr = 1, dm_rd = 0.
REQ-015 SHALL assert cpu_stall = cpu_act & dma_sel combinationally in the same cycle; CPU holds its request and retries next cycle.
REQ-016 SHALL drive dma_gnt = dma_sel combinationally; DMA holds req/addr/wdata/we stable until the gnt cycle.
REQ-017 SHALL drive cpu_rdata = dm_rdata when CPU owns the cycle, else 32'h0.
REQ-018 SHALL register dma_rdata <= dm_rdata and dma_rvalid <= 1 on the clock ending a granted DMA read; dma_rvalid SHALL be 0 in all other cycles (one-cycle pulse, latency 1).
REQ-019 SHALL keep a 3-bit wait_cnt: clear when dma_sel or ~dma_req; else increment, saturating at STARVE_LIMIT.
REQ-020 SHALL, on forced grant (wait_cnt == STARVE_LIMIT with cpu_act), give exactly one cycle to DMA; wait_cnt clears, so CPU wins the next STARVE_LIMIT contended cycles.
REQ-021 SHALL order same-address collisions by grant: a forced DMA write is visible to the CPU retry in the following cycle.
REQ-022 SHALL, with neither requester active, drive dm_rd = dm_wr = 0, dm_addr/dm_wdata from CPU fields.

Reset
REQ-023 SHALL, while reset is high, force dm_rd, dm_wr, dma_gnt, cpu_stall to 0 combinationally.
REQ-024 SHALL on a clock with reset high set wait_cnt = 0, dma_rvalid = 0, dma_rdata = 32'h0.
REQ-025 SHALL abandon any in-progress DMA read when reset arrives; no dma_rvalid pulse follows it.

Structure
REQ-026 SHALL place the address width (7), data width (32) and STARVE_LIMIT default in a shared include header used with the data memory and MEM stage.
REQ-027 SHALL be a single module with no sub-modules; the data memory is instantiated by the parent alongside it.

Verification
REQ-028 CPU-only: cpu_wr=1, addr 5, data 32'hDEADBEEF, then cpu_rd addr 5 -> dm_wr then cpu_rdata=32'hDEADBEEF, cpu_stall=0 throughout.
REQ-029 DMA-only: dma_req=1, dma_we=0, addr 5 -> dma_gnt same cycle, dma_rvalid=1 with dma_rdata=32'hDEADBEEF next cycle, single pulse.
REQ-030 Starvation: cpu_rd held high, dma_req held high, STARVE_LIMIT=4 -> dma_gnt=1 and cpu_stall=1 on the 5th cycle only, repeating every 5 cycles.
REQ-031 Collision: CPU reads addr 9 contending with DMA write 32'h12345678 to addr 9 at forced grant -> CPU retry returns 32'h12345678.
REQ-032 Dual strobe: cpu_rd=cpu_wr=1 -> dm_wr=1, dm_rd=0.
REQ-033 Reset mid-read: reset asserted in the dma_gnt cycle of a DMA read -> dma_rvalid stays 0, wait_cnt=0, dm_rd=0.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared widths and payload types for the data-memory arbiter, its memory and the MEM stage.
package dm_arbiter_pkg;

  localparam int unsigned ADDR_W           = 7;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned CNT_W            = 3;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // One data-memory access request as seen by the memory port.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, DMA and data-memory signals of the arbiter, bundled for port connection.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
();

  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dm_addr, dm_rd, dm_wr, dm_wdata,
    input  dm_rdata
  );

  // Requester / memory side.
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dm_addr, dm_rd, dm_wr, dm_wdata,
    output dm_rdata
  );

endinterface

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU has priority, DMA is force-granted one
// cycle after STARVE_LIMIT consecutive contended cycles.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  dm_arbiter_if.slave   bus
);

  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic              dma_rvalid_q;
  logic              dma_rvalid_nxt;
  logic [DATA_W-1:0] dma_rdata_q;
  logic [DATA_W-1:0] dma_rdata_nxt;

  logic              cpu_act;
  logic              starved;
  logic              dma_sel;
  mem_cmd_t          cpu_cmd;
  mem_cmd_t          dma_cmd;
  mem_cmd_t          dm_cmd;

  // Port selection, memory drive and next state of the wait counter / read return.
  always_comb begin
    cpu_act        = bus.cpu_rd | bus.cpu_wr;
    starved        = (wait_cnt == CNT_W'(STARVE_LIMIT));
    dma_sel        = bus.dma_req & (~cpu_act | starved) & ~reset;

    // Dual strobe from the CPU resolves to a write.
    cpu_cmd.rd     = bus.cpu_rd & ~bus.cpu_wr;
    cpu_cmd.wr     = bus.cpu_wr;
    cpu_cmd.addr   = bus.cpu_addr;
    cpu_cmd.wdata  = bus.cpu_wdata;

    dma_cmd.rd     = ~bus.dma_we;
    dma_cmd.wr     = bus.dma_we;
    dma_cmd.addr   = bus.dma_addr;
    dma_cmd.wdata  = bus.dma_wdata;

    dm_cmd         = dma_sel ? dma_cmd : cpu_cmd;

    bus.dm_addr    = dm_cmd.addr;
    bus.dm_wdata   = dm_cmd.wdata;
    bus.dm_rd      = dm_cmd.rd & ~reset;
    bus.dm_wr      = dm_cmd.wr & ~reset;

    bus.dma_gnt    = dma_sel;
    bus.cpu_stall  = cpu_act & dma_sel;
    bus.cpu_rdata  = dma_sel ? '0 : bus.dm_rdata;

    bus.dma_rvalid = dma_rvalid_q;
    bus.dma_rdata  = dma_rdata_q;

    // Counter tracks consecutive refused DMA cycles; any grant or idle DMA clears it.
    wait_cnt_nxt   = wait_cnt;
    if (dma_sel || !bus.dma_req) begin
      wait_cnt_nxt = '0;
    end else if (!starved) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end

    dma_rvalid_nxt = dma_sel & ~bus.dma_we;
    dma_rdata_nxt  = dma_rvalid_nxt ? bus.dm_rdata : dma_rdata_q;
  end

  // State registers; reset also drops any DMA read granted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      wait_cnt     <= wait_cnt_nxt;
      dma_rvalid_q <= dma_rvalid_nxt;
      dma_rdata_q  <= dma_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed and randomized bench for dm_arbiter against a behavioural model.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dm_arbiter_if bus ();

  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory seen by the arbiter (combinational read, clocked write).
  logic [31:0] mem [128];
  always @(posedge clk) if (bus.dm_wr) mem[bus.dm_addr] <= bus.dm_wdata;
  assign bus.dm_rdata = mem[bus.dm_addr];

  // Reference model state.
  logic [31:0] ref_mem [128];
  int          denied;        // consecutive cycles a pending DMA request was refused
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  logic        last_sel;
  logic        last_stall;

  int checks = 0;
  int errors = 0;

  // DUT observations captured during the last step.
  logic        obs_gnt, obs_stall, obs_dm_rd, obs_dm_wr, obs_rvalid;
  logic [31:0] obs_cpu_rdata, obs_dma_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input int addr, input logic [31:0] wd);
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = 7'(addr);
    bus.cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic we, input int addr, input logic [31:0] wd);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = 7'(addr);
    bus.dma_wdata = wd;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    bit act, sel;
    #2;
    act = bus.cpu_rd || bus.cpu_wr;
    sel = !reset && bus.dma_req && (!act || denied >= LIMIT);
    obs_gnt = bus.dma_gnt; obs_stall = bus.cpu_stall;
    obs_dm_rd = bus.dm_rd; obs_dm_wr = bus.dm_wr; obs_cpu_rdata = bus.cpu_rdata;
    chk("dma_gnt", 32'(bus.dma_gnt), 32'(sel));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(act && sel));
    chk("dm_wr", 32'(bus.dm_wr), reset ? 32'd0 : (sel ? 32'(bus.dma_we) : 32'(bus.cpu_wr)));
    chk("dm_rd", 32'(bus.dm_rd),
        reset ? 32'd0 : (sel ? 32'(!bus.dma_we) : 32'(bus.cpu_rd && !bus.cpu_wr)));
    chk("dm_addr", 32'(bus.dm_addr), sel ? 32'(bus.dma_addr) : 32'(bus.cpu_addr));
    chk("dm_wdata", bus.dm_wdata, sel ? bus.dma_wdata : bus.cpu_wdata);
    if (sel) chk("cpu_rdata", bus.cpu_rdata, 32'h0);
    else if (act) chk("cpu_rdata", bus.cpu_rdata, ref_mem[bus.cpu_addr]);
    last_sel   = sel;
    last_stall = act && sel;
    @(posedge clk);
    if (reset) begin
      denied = 0; exp_rvalid = 1'b0; exp_rdata = 32'h0;
    end else begin
      exp_rvalid = 1'b0;
      if (sel) begin
        if (bus.dma_we) ref_mem[bus.dma_addr] = bus.dma_wdata;
        else begin
          exp_rvalid = 1'b1;
          exp_rdata  = ref_mem[bus.dma_addr];
        end
        denied = 0;
      end else begin
        if (bus.cpu_wr) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        denied = bus.dma_req ? denied + 1 : 0;
      end
    end
    #1;
    obs_rvalid = bus.dma_rvalid; obs_dma_rdata = bus.dma_rdata;
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(exp_rvalid));
    chk("dma_rdata", bus.dma_rdata, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    int          r;
    for (int i = 0; i < 128; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    denied = 0; exp_rvalid = 1'b0; exp_rdata = 32'h0;
    last_sel = 1'b0; last_stall = 1'b0;
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 3, 32'h0);
    set_dma(1'b1, 1'b0, 4, 32'h0);
    @(negedge clk);

    // Reset with both requesters active: no access, no grant, no stall.
    step();
    chk("rst_dm_rd", 32'(obs_dm_rd), 32'd0);
    chk("rst_gnt", 32'(obs_gnt), 32'd0);
    step();
    chk("rst_rvalid", 32'(obs_rvalid), 32'd0);
    chk("rst_rdata", obs_dma_rdata, 32'h0);
    reset = 1'b0;
    set_dma(1'b0, 1'b0, 0, 32'h0);

    // CPU-only write then read back.
    set_cpu(1'b0, 1'b1, 5, 32'hDEADBEEF); step();
    chk("cpu_wr_dm_wr", 32'(obs_dm_wr), 32'd1);
    chk("cpu_wr_stall", 32'(obs_stall), 32'd0);
    set_cpu(1'b1, 1'b0, 5, 32'h0); step();
    chk("cpu_rd_data", obs_cpu_rdata, 32'hDEADBEEF);
    chk("cpu_rd_stall", 32'(obs_stall), 32'd0);

    // DMA-only read: grant now, single rvalid pulse next cycle.
    set_cpu(1'b0, 1'b0, 0, 32'h0);
    set_dma(1'b1, 1'b0, 5, 32'h0); step();
    chk("dma_rd_gnt", 32'(obs_gnt), 32'd1);
    chk("dma_rd_rvalid", 32'(obs_rvalid), 32'd1);
    chk("dma_rd_rdata", obs_dma_rdata, 32'hDEADBEEF);
    set_dma(1'b0, 1'b0, 0, 32'h0); step();
    chk("dma_rd_pulse", 32'(obs_rvalid), 32'd0);

    // Starvation: forced grant every fifth contended cycle.
    set_cpu(1'b1, 1'b0, 3, 32'h0);
    set_dma(1'b1, 1'b0, 7, 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("starve_gnt", 32'(obs_gnt), 32'((i % 5) == 4));
      chk("starve_stall", 32'(obs_stall), 32'((i % 5) == 4));
    end
    set_dma(1'b0, 1'b0, 0, 32'h0);
    set_cpu(1'b0, 1'b0, 0, 32'h0); step();

    // Collision: forced DMA write is seen by the CPU retry.
    set_cpu(1'b1, 1'b0, 9, 32'h0);
    set_dma(1'b1, 1'b1, 9, 32'h12345678);
    for (int i = 0; i < 5; i++) step();
    chk("coll_gnt", 32'(obs_gnt), 32'd1);
    set_dma(1'b0, 1'b0, 0, 32'h0); step();
    chk("coll_retry", obs_cpu_rdata, 32'h12345678);

    // Dual strobe acts as a write.
    set_cpu(1'b1, 1'b1, 11, 32'hA5A5_0011); step();
    chk("dual_dm_wr", 32'(obs_dm_wr), 32'd1);
    chk("dual_dm_rd", 32'(obs_dm_rd), 32'd0);

    // Reset arriving in the grant cycle of a DMA read.
    set_cpu(1'b1, 1'b0, 1, 32'h0);
    set_dma(1'b1, 1'b0, 2, 32'h0);
    step(); step();
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 0, 32'h0); step();
    chk("rmr_dm_rd", 32'(obs_dm_rd), 32'd0);
    chk("rmr_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    reset = 1'b0;
    set_dma(1'b0, 1'b0, 0, 32'h0); step();
    chk("rmr_rvalid", 32'(obs_rvalid), 32'd0);

    // Randomized traffic; stalled CPU and waiting DMA hold their requests.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!last_stall) begin
        r = $urandom_range(0, 7);
        set_cpu(r inside {1, 2, 3, 6}, r inside {4, 5, 6}, $urandom_range(0, 15), $urandom);
      end
      if (!(bus.dma_req && !last_sel)) begin
        set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15), $urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
